uart_rx_fifo: RTL

Parametrised next-generation UART receive path for the smart-watch command channel, which carries the ASCII command bytes 'M', 'T', 'R', 'L', 'U', 'D', 'H' and 'S'. It combines the following in one block:
- an oversampling receiver with configurable data bits and parity;
- glitch rejection on the start bit;
- framing and parity error reporting;
- a first-word-fall-through receive FIFO of configurable depth with sticky overflow.
It sits between the board rx pin and the command decoder in the top level.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/sync_fifo_fwft.sv | 68 ++++++
 rtl/uart_rx_fifo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, receiver
// state encoding and the command-channel ASCII bytes.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  localparam logic [7:0] CMD_M = 8'h4D;
  localparam logic [7:0] CMD_T = 8'h54;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_U = 8'h55;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_S = 8'h53;

  // Clocks per oversampling tick; truncation is intentional.
  function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
    return clk_freq / (baud * ovs);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head; full/empty come
// straight from the occupancy count.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign rd_ptr_n = do_pop ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_n;

      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // The incoming word becomes the head when nothing older remains after
      // this cycle's pop; otherwise the head moves to the next stored slot.
      if (do_push && (wr_ptr == rd_ptr_n)) begin
        rd_data <= wdata;
      end else if (do_pop && (count != CW'(1))) begin
        rd_data <= mem[rd_ptr_n];
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with start-glitch rejection, framing/parity
// error pulses and a FWFT receive FIFO with sticky overflow.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | line high, waiting for a falling edge on the synced rx
// START    | counting to mid start bit to confirm it is not a glitch
// DATA     | sampling DATA_BITS data bits LSB first at mid-bit
// PARITY   | sampling the parity bit and latching the mismatch flag
// STOP     | sampling the stop bit; push byte or report an error
// BREAK    | line held low after a framing error, wait for it to rise
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVS        = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx,
  input  logic                              rd_en,
  input  logic                              ovf_clr,
  output logic [DATA_BITS-1:0]              rd_data,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              overflow
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVS);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SUB_W = $clog2(OVS);

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
  localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(OVS / 2 - 1);
  localparam logic [SUB_W-1:0] SUB_FULL = SUB_W'(OVS - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic                 start_det;
  logic [SUB_W-1:0]     sub_cnt;
  logic                 sample;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bad;
  logic                 push;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Tick down-counter free-runs, and is re-phased on the start edge.
  assign start_det = (state == ST_IDLE) && !rx_s;
  assign tick      = (div_cnt == '0);
  assign sample    = tick && (sub_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= DIV_LOAD;
    end else if (start_det || tick) begin
      div_cnt <= DIV_LOAD;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sub_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      bad        <= 1'b0;
      push       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      push       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      if (sample) begin
        sub_cnt <= SUB_FULL;
      end else if (tick) begin
        sub_cnt <= sub_cnt - 1'b1;
      end

      case (state)
        ST_IDLE: begin
          bad <= 1'b0;
          if (!rx_s) begin
            state   <= ST_START;
            sub_cnt <= SUB_HALF;
          end
        end
        ST_START: begin
          if (sample) begin
            bit_cnt <= BIT_LAST;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (sample) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == '0) begin
              state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (sample) begin
            bad   <= ((^shreg) ^ rx_s) != (PARITY == PAR_ODD);
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample) begin
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end else if (bad) begin
              parity_err <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              push  <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A simultaneous read frees a slot, so only an unread full FIFO drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && full && !rd_en) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   (shreg),
    .pop     (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule
